// File: rtl/set_monitor.sv
// Line driver with timed holds, plus a synchronized monitor that checks or waits
// for levels on an asynchronous input bundle.
module set_monitor #(
  parameter int N  = 1,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_valid,
  output logic          set_ready,
  input  logic [N-1:0]  set_value,
  input  logic [CW-1:0] set_cycles,
  output logic          set_done,
  output logic [N-1:0]  signals_out,
  input  logic [N-1:0]  signals_in,
  input  logic          mon_valid,
  input  logic [1:0]    mon_op,
  input  logic [CW-1:0] mon_cycles,
  output logic          mon_ready,
  output logic          mon_done,
  output logic          mon_ok,
  output logic [N-1:0]  mon_sample
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_WAIT_LOW   = 2'b00;
  localparam logic [1:0] OP_ENS_LOW    = 2'b01;
  localparam logic [1:0] OP_ENS_HIGH   = 2'b10;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // ---------------- driver ----------------
  logic          set_busy_reg;
  logic [CW-1:0] set_cnt_reg;
  logic [N-1:0]  out_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_busy_reg <= 1'b0;
      set_cnt_reg  <= '0;
      out_reg      <= '1;
    end else if (!set_busy_reg) begin
      if (set_valid) begin
        set_busy_reg <= 1'b1;
        out_reg      <= set_value;
        set_cnt_reg  <= (set_cycles == '0) ? CNT_ONE : set_cycles;
      end
    end else begin
      // the counter holds the number of hold cycles still to come, this one included
      if (set_cnt_reg == CNT_ONE) begin
        set_busy_reg <= 1'b0;
      end else begin
        set_cnt_reg <= set_cnt_reg - CNT_ONE;
      end
    end
  end

  assign set_ready   = !set_busy_reg;
  assign set_done    = set_busy_reg && (set_cnt_reg == CNT_ONE);
  assign signals_out = out_reg;

  // ---------------- monitor ----------------
  logic [N-1:0]  sync1_reg;
  logic [N-1:0]  sync2_reg;
  logic [1:0]    state_reg;
  logic [CW-1:0] mon_cnt_reg;
  logic [N-1:0]  ref_reg;
  logic          ok_reg;
  logic          res_ok_reg;
  logic [N-1:0]  res_sample_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg      <= '1;
      sync2_reg      <= '1;
      state_reg      <= ST_IDLE;
      mon_cnt_reg    <= '0;
      ref_reg        <= '0;
      ok_reg         <= 1'b0;
      res_ok_reg     <= 1'b0;
      res_sample_reg <= '0;
    end else begin
      sync1_reg <= signals_in;
      sync2_reg <= sync1_reg;
      case (state_reg)
        ST_IDLE: begin
          if (mon_valid) begin
            ok_reg      <= 1'b1;
            mon_cnt_reg <= (mon_cycles == '0) ? CNT_ONE : mon_cycles;
            if (mon_op == OP_WAIT_LOW) begin
              state_reg <= ST_WAIT;
            end else begin
              state_reg <= ST_CHECK;
            end
            if (mon_op == OP_ENS_LOW) begin
              ref_reg <= '0;
            end else if (mon_op == OP_ENS_HIGH) begin
              ref_reg <= '1;
            end else begin
              ref_reg <= sync2_reg;
            end
          end
        end
        ST_WAIT: begin
          if (sync2_reg == '0) begin
            state_reg <= ST_DONE;
          end
        end
        ST_CHECK: begin
          // a mismatch is sticky but the check always runs its full length
          if (sync2_reg != ref_reg) begin
            ok_reg <= 1'b0;
          end
          if (mon_cnt_reg == CNT_ONE) begin
            state_reg <= ST_DONE;
          end else begin
            mon_cnt_reg <= mon_cnt_reg - CNT_ONE;
          end
        end
        default: begin
          res_ok_reg     <= ok_reg;
          res_sample_reg <= sync2_reg;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  // results appear live during DONE and are held in registers afterwards
  assign mon_ready  = (state_reg == ST_IDLE);
  assign mon_done   = (state_reg == ST_DONE);
  assign mon_ok     = mon_done ? ok_reg : res_ok_reg;
  assign mon_sample = mon_done ? sync2_reg : res_sample_reg;

endmodule

// File: tb/tb_set_monitor.sv
// Randomized self-checking bench for set_monitor against a cycle-indexed
// reference model of driver holds and synchronized monitor checks.
module tb_set_monitor;
  localparam int N  = 1;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          set_valid = 1'b0;
  logic          set_ready;
  logic [N-1:0]  set_value = '0;
  logic [CW-1:0] set_cycles = '0;
  logic          set_done;
  logic [N-1:0]  signals_out;
  logic [N-1:0]  signals_in;
  logic          mon_valid = 1'b0;
  logic [1:0]    mon_op = 2'b00;
  logic [CW-1:0] mon_cycles = '0;
  logic          mon_ready;
  logic          mon_done;
  logic          mon_ok;
  logic [N-1:0]  mon_sample;

  logic          loop_en = 1'b0;
  logic [N-1:0]  in_drv = '1;
  assign signals_in = loop_en ? signals_out : in_drv;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  logic [N-1:0] hist [0:65535];

  set_monitor #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .set_valid(set_valid), .set_ready(set_ready), .set_value(set_value),
    .set_cycles(set_cycles), .set_done(set_done), .signals_out(signals_out),
    .signals_in(signals_in), .mon_valid(mon_valid), .mon_op(mon_op),
    .mon_cycles(mon_cycles), .mon_ready(mon_ready), .mon_done(mon_done),
    .mon_ok(mon_ok), .mon_sample(mon_sample)
  );

  always #5 clk = ~clk;

  // hist[k] is the input level present during cycle k (driven just after edge k)
  always @(posedge clk) begin
    hist[cyc % 65536] = signals_in;
    cyc = cyc + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // synchronized value seen by the monitor during cycle c: two cycles of delay
  function automatic logic [N-1:0] s_at(input int c);
    return hist[(c - 2) % 65536];
  endfunction

  task automatic drive_cmd(input logic [N-1:0] v, input logic [CW-1:0] n,
                           input bit poke, output int dones);
    int k;
    int w;
    dones = 0;
    w = 0;
    while (!set_ready && w < 2000) begin
      tick();
      w++;
    end
    tests++;
    if (set_ready !== 1'b1) begin
      errors++;
      $display("FAIL drv_ready_timeout got=%b want=1", set_ready);
      return;
    end
    set_value  = v;
    set_cycles = n;
    set_valid  = 1'b1;
    tick();
    set_valid = 1'b0;
    set_value = N'($urandom);
    k = (n == 0) ? 1 : int'(n);
    for (int i = 1; i <= k; i++) begin
      tests++;
      if (signals_out !== v) begin
        errors++;
        $display("FAIL drv_level hold=%0d got=%b want=%b", i, signals_out, v);
      end
      tests++;
      if (set_ready !== 1'b0) begin
        errors++;
        $display("FAIL drv_busy hold=%0d got=%b want=0", i, set_ready);
      end
      tests++;
      if (set_done !== (i == k)) begin
        errors++;
        $display("FAIL drv_done hold=%0d got=%b want=%b", i, set_done, (i == k));
      end
      if (set_done === 1'b1) dones++;
      if (poke) begin
        set_valid  = 1'b1;
        set_value  = ~v;
        set_cycles = CW'($urandom_range(1, 5));
      end
      tick();
    end
    set_valid = 1'b0;
    tests++;
    if (set_ready !== 1'b1 || set_done !== 1'b0 || signals_out !== v) begin
      errors++;
      $display("FAIL drv_after got=rdy%b done%b out%b want=rdy1 done0 out%b",
               set_ready, set_done, signals_out, v);
    end
    $display("[TB] drive v=%b cycles=%0d poke=%0d dones=%0d", v, n, poke, dones);
  endtask

  // pat 0: sticky random input, 1: constant base with optional glitch, 2: leave input alone
  task automatic run_mon(input logic [1:0] op, input logic [CW-1:0] n, input int pat,
                         input logic [N-1:0] base, input int glitch);
    int c0;
    int k;
    int w;
    logic [N-1:0] refv;
    logic exp_ok;
    logic [N-1:0] exp_s;
    w = 0;
    while (!mon_ready && w < 2000) begin
      tick();
      w++;
    end
    tests++;
    if (mon_ready !== 1'b1) begin
      errors++;
      $display("FAIL mon_ready_timeout got=%b want=1", mon_ready);
      return;
    end
    c0 = cyc;
    mon_valid  = 1'b1;
    mon_op     = op;
    mon_cycles = n;
    tick();
    mon_valid = 1'b0;
    k = (n == 0) ? 1 : int'(n);
    for (int j = 1; j <= k; j++) begin
      if (pat == 1) in_drv = (j == glitch) ? ~base : base;
      else if (pat == 0 && $urandom_range(0, 7) == 0) in_drv = ~in_drv;
      mon_valid = 1'($urandom);
      mon_op    = 2'($urandom);
      tests++;
      if (mon_done !== 1'b0 || mon_ready !== 1'b0) begin
        errors++;
        $display("FAIL mon_busy step=%0d got=done%b rdy%b want=done0 rdy0", j, mon_done, mon_ready);
      end
      tick();
    end
    mon_valid = 1'b0;
    if (op == 2'b01) refv = '0;
    else if (op == 2'b10) refv = '1;
    else refv = s_at(c0);
    exp_ok = 1'b1;
    for (int c = c0 + 1; c <= c0 + k; c++) begin
      if (s_at(c) != refv) exp_ok = 1'b0;
    end
    exp_s = s_at(c0 + k + 1);
    tests++;
    if (mon_done !== 1'b1 || mon_ok !== exp_ok || mon_sample !== exp_s) begin
      errors++;
      $display("FAIL mon_result op=%0d n=%0d got=done%b ok%b s%b want=done1 ok%b s%b",
               op, n, mon_done, mon_ok, mon_sample, exp_ok, exp_s);
    end
    tick();
    tests++;
    if (mon_done !== 1'b0 || mon_ready !== 1'b1 || mon_ok !== exp_ok || mon_sample !== exp_s) begin
      errors++;
      $display("FAIL mon_hold got=done%b rdy%b ok%b s%b want=done0 rdy1 ok%b s%b",
               mon_done, mon_ready, mon_ok, mon_sample, exp_ok, exp_s);
    end
    $display("[TB] mon op=%0d cycles=%0d ok=%b sample=%b", op, n, exp_ok, exp_s);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_drv = '1;
    repeat (3) tick();
    tests++;
    if ({signals_out, set_ready, set_done, mon_ready, mon_done, mon_ok, mon_sample} !==
        {{N{1'b1}}, 5'b10100, {N{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state got=out%b rdy%b done%b mrdy%b mdone%b ok%b s%b", signals_out,
               set_ready, set_done, mon_ready, mon_done, mon_ok, mon_sample);
    end
    rst = 1'b0;
    repeat (3) tick();
    tests++;
    if (signals_out !== '1 || set_ready !== 1'b1 || mon_ready !== 1'b1 || mon_ok !== 1'b0) begin
      errors++;
      $display("FAIL after_release got=out%b rdy%b mrdy%b ok%b want=out1 rdy1 mrdy1 ok0",
               signals_out, set_ready, mon_ready, mon_ok);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_drive_basic;
    int d;
    drive_cmd('0, 16'd4, 1'b1, d);
    tests++;
    if (d != 1) begin
      errors++;
      $display("FAIL basic_dones got=%0d want=1", d);
    end
    drive_cmd('0, 16'd0, 1'b0, d);
    tests++;
    if (d != 1) begin
      errors++;
      $display("FAIL zero_cycles_dones got=%0d want=1", d);
    end
  endtask

  task automatic test_uart;
    logic [9:0] frame;
    int d;
    int total;
    frame = {1'b1, 8'h3F, 1'b0};
    total = 0;
    loop_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cmd(N'(frame[i]), 16'd868, 1'b0, d);
      total += d;
    end
    in_drv = '1;
    loop_en = 1'b0;
    tests++;
    if (total != 10) begin
      errors++;
      $display("FAIL uart_dones got=%0d want=10", total);
    end
  endtask

  task automatic test_wait_for_low;
    int td;
    int w;
    in_drv = '1;
    repeat (4) tick();
    mon_valid = 1'b1;
    mon_op = 2'b00;
    mon_cycles = CW'($urandom);
    tick();
    mon_valid = 1'b0;
    for (int j = 1; j < 20; j++) begin
      tests++;
      if (mon_done !== 1'b0) begin
        errors++;
        $display("FAIL wait_early step=%0d got=%b want=0", j, mon_done);
      end
      tick();
    end
    in_drv = '0;
    td = cyc;
    w = 0;
    while (mon_done !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    tests++;
    if (mon_done !== 1'b1 || (cyc - td) != 3 || mon_ok !== 1'b1 || mon_sample !== '0) begin
      errors++;
      $display("FAIL wait_low got=done%b lat%0d ok%b s%b want=done1 lat3 ok1 s0",
               mon_done, cyc - td, mon_ok, mon_sample);
    end
    tick();
    $display("[TB] wait_for_low latency=%0d", cyc - td - 1);
  endtask

  task automatic test_ensure;
    in_drv = '0;
    repeat (3) tick();
    run_mon(2'b01, 16'd8, 1, '0, 4);
    run_mon(2'b01, 16'd8, 1, '0, 0);
    in_drv = '1;
    repeat (3) tick();
    run_mon(2'b10, 16'd6, 1, '1, 0);
    run_mon(2'b10, 16'd0, 1, '1, 1);
    run_mon(2'b11, 16'd5, 1, '1, 3);
    run_mon(2'b11, 16'd5, 1, '1, 0);
  endtask

  task automatic test_random;
    int d;
    for (int i = 0; i < 12; i++) begin
      in_drv = N'($urandom);
      run_mon(2'($urandom_range(1, 3)), CW'($urandom_range(0, 12)), 0, '0, 0);
      drive_cmd(N'($urandom), CW'($urandom_range(0, 6)), 1'($urandom), d);
    end
  endtask

  task automatic test_concurrent;
    int d;
    loop_en = 1'b1;
    fork
      drive_cmd('0, 16'd30, 1'b0, d);
      begin
        tick();
        tick();
        run_mon(2'b01, 16'd10, 2, '0, 0);
      end
    join
    drive_cmd('1, 16'd3, 1'b0, d);
    in_drv = '1;
    loop_en = 1'b0;
  endtask

  task automatic test_abort;
    int d;
    in_drv = '1;
    repeat (3) tick();
    set_valid = 1'b1;
    set_value = '0;
    set_cycles = 16'd200;
    mon_valid = 1'b1;
    mon_op = 2'b11;
    mon_cycles = 16'd100;
    tick();
    set_valid = 1'b0;
    mon_valid = 1'b0;
    repeat (30) tick();
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({signals_out, set_ready, set_done, mon_ready, mon_done, mon_ok, mon_sample} !==
        {{N{1'b1}}, 5'b10100, {N{1'b0}}}) begin
      errors++;
      $display("FAIL abort_state got=out%b rdy%b done%b mrdy%b mdone%b ok%b s%b", signals_out,
               set_ready, set_done, mon_ready, mon_done, mon_ok, mon_sample);
    end
    tick();
    rst = 1'b0;
    for (int j = 0; j < 110; j++) begin
      tests++;
      if (set_done !== 1'b0 || mon_done !== 1'b0 || signals_out !== '1) begin
        errors++;
        $display("FAIL abort_quiet step=%0d got=sd%b md%b out%b want=sd0 md0 out1",
                 j, set_done, mon_done, signals_out);
      end
      tick();
    end
    drive_cmd('0, 16'd0, 1'b0, d);
    tests++;
    if (d != 1) begin
      errors++;
      $display("FAIL abort_next_dones got=%0d want=1", d);
    end
    run_mon(2'b10, 16'd4, 1, '1, 0);
    $display("[TB] abort checked");
  endtask

  initial begin
    test_reset();
    test_drive_basic();
    test_uart();
    test_wait_for_low();
    test_ensure();
    test_random();
    test_concurrent();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
